// File: rtl/instr_encoder_pkg.sv
// Shared types for the RV32I instruction encoder.
// Owns the opcode constants and the field-packing function.
package instr_encoder_pkg;

    typedef logic [6:0]  opcode_t;
    typedef logic [31:0] imm_t;

    localparam opcode_t RType       = 7'b0110011;
    localparam opcode_t IType_logic = 7'b0010011;
    localparam opcode_t IType_load  = 7'b0000011;
    localparam opcode_t IType_jalr  = 7'b1100111;
    localparam opcode_t SType       = 7'b0100011;
    localparam opcode_t BType       = 7'b1100011;
    localparam opcode_t JType       = 7'b1101111;
    localparam opcode_t UType_auipc = 7'b0010111;
    localparam opcode_t UType_lui   = 7'b0110111;

    typedef enum logic {ST_FILL, ST_DONE} state_t;

    // Returns {illegal, word}.
    function automatic logic [32:0] encode(
        input opcode_t    op,
        input logic [2:0] f3,
        input logic [6:0] f7,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input imm_t       imm
    );
        logic [31:0] w;
        logic        bad;
        w   = '0;
        bad = 1'b0;
        case (op)
            RType:
                w = {f7, rs2, rs1, f3, rd, op};
            IType_logic:
                if (f3 == 3'b001 || f3 == 3'b101)
                    w = {f7, imm[4:0], rs1, f3, rd, op};
                else
                    w = {imm[11:0], rs1, f3, rd, op};
            IType_load:
                w = {imm[11:0], rs1, f3, rd, op};
            IType_jalr:
                w = {imm[11:0], rs1, 3'b000, rd, op};
            SType:
                w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            BType: begin
                w   = {imm[12], imm[10:5], rs2, rs1, f3,
                       imm[4:1], imm[11], op};
                bad = imm[0];
            end
            JType: begin
                w   = {imm[20], imm[10:1], imm[11],
                       imm[19:12], rd, op};
                bad = imm[0];
            end
            UType_lui, UType_auipc:
                w = {imm[31:12], rd, op};
            default:
                bad = 1'b1;
        endcase
        return {bad, w};
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle input handshake and instruction-memory write port.
interface instr_encoder_if #(
    parameter int ADDR_W = 10
);
    import instr_encoder_pkg::*;

    logic              in_valid;
    logic              in_ready;
    opcode_t           in_opcode;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    imm_t              in_imm;
    logic              mem_we;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output in_valid, in_opcode, in_funct3, in_funct7,
        output in_rd, in_rs1, in_rs2, in_imm, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_opcode, in_funct3, in_funct7,
        input  in_rd, in_rs1, in_rs2, in_imm, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/instr_encoder_fifo.sv
// Small synchronous FIFO for encoded words, with a one-cycle flush.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW:0]      wr_q, wr_d;
    logic [PW:0]      rd_q, rd_d;

    // Extra pointer bit distinguishes full from empty.
    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[PW] != rd_q[PW]) &&
                   (wr_q[PW-1:0] == rd_q[PW-1:0]);
    assign head  = mem_q[rd_q[PW-1:0]];

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (push) wr_d = wr_q + 1'b1;
            if (pop)  rd_d = rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            if (push && !flush) mem_q[wr_q[PW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs decoded RV32I fields into instruction words and streams
// them to instruction memory at consecutive word addresses.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter int          ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    instr_encoder_if.slave    bus,
    output logic              illegal,
    output logic [ADDR_W:0]   count,
    output logic              done
);
    localparam logic [ADDR_W-1:0] BASE = BASE_ADDR[ADDR_W-1:0];

    state_t            state_q, state_d;
    logic              live_q, live_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              illegal_q, illegal_d;

    logic [32:0] enc;
    logic        full, empty, flush;
    logic        accept, push, pop, filling;

    assign enc = encode(bus.in_opcode, bus.in_funct3,
                        bus.in_funct7, bus.in_rd,
                        bus.in_rs1, bus.in_rs2, bus.in_imm);

    assign filling      = (state_q == ST_FILL);
    assign bus.in_ready = live_q && !full && filling && !clear;
    assign bus.mem_we   = !empty && filling;
    assign bus.mem_addr = addr_q;
    assign accept       = bus.in_valid && bus.in_ready;
    assign push         = accept && !enc[32];
    assign pop          = bus.mem_we && bus.mem_ready && !clear;
    // Leftover words are dropped while the program space is full.
    assign flush        = clear || !filling;

    assign illegal = illegal_q;
    assign count   = count_q;
    assign done    = (state_q == ST_DONE);

    always_comb begin
        state_d   = state_q;
        live_d    = 1'b1;
        addr_d    = addr_q;
        count_d   = count_q;
        illegal_d = accept && enc[32];
        if (clear) begin
            state_d = ST_FILL;
            addr_d  = BASE;
            count_d = '0;
        end else if (pop) begin
            count_d = count_q + 1'b1;
            if (addr_q == '1) state_d = ST_DONE;
            else              addr_d  = addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_FILL;
            live_q    <= 1'b0;
            addr_q    <= BASE;
            count_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            live_q    <= live_d;
            addr_q    <= addr_d;
            count_q   <= count_d;
            illegal_q <= illegal_d;
        end
    end

    instr_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .push    (push),
        .pop     (pop),
        .wdata   (enc[31:0]),
        .full    (full),
        .empty   (empty),
        .head    (bus.mem_wdata)
    );

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized bench for instr_encoder against a transaction-level
// model of the encoding rules, FIFO occupancy and address space.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 3;
    localparam int NW    = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          clear = 1'b0;
    logic          illegal;
    logic [AW:0]   count;
    logic          done;

    always #5 clk = ~clk;

    instr_encoder_if #(.ADDR_W(AW)) bus ();

    instr_encoder #(
        .DEPTH     (DEPTH),
        .ADDR_W    (AW),
        .BASE_ADDR (0)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .bus     (bus.slave),
        .illegal (illegal),
        .count   (count),
        .done    (done)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] q[$];
    int          exp_addr, exp_count, ill_seen;
    bit          exp_done, live, pend_ill;
    logic [31:0] wlog[NW];

    task automatic check(string tag, logic [31:0] got,
                         logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference encoder: field placement with shifts and masks.
    function automatic bit [32:0] ref_enc(
        bit [31:0] op, bit [31:0] f3, bit [31:0] f7, bit [31:0] rd,
        bit [31:0] rs1, bit [31:0] rs2, bit [31:0] imm);
        bit [31:0] w, regs, ii;
        bit        bad;
        bad  = 0;
        w    = 0;
        regs = (rs2 << 20) | (rs1 << 15) | (f3 << 12);
        ii   = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (rd << 7) | op;
        case (op)
            32'h33: w = (f7 << 25) | regs | (rd << 7) | op;
            32'h13:
                if (f3 == 1 || f3 == 5)
                    w = (f7 << 25) | ((imm & 31) << 20) | (rs1 << 15)
                      | (f3 << 12) | (rd << 7) | op;
                else
                    w = ii | (f3 << 12);
            32'h03: w = ii | (f3 << 12);
            32'h67: w = ii;
            32'h23: w = (((imm >> 5) & 127) << 25) | regs
                      | ((imm & 31) << 7) | op;
            32'h63: begin
                w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25)
                  | regs | (((imm >> 1) & 15) << 8)
                  | (((imm >> 11) & 1) << 7) | op;
                bad = imm[0];
            end
            32'h6F: begin
                w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 1023) << 21)
                  | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 255) << 12)
                  | (rd << 7) | op;
                bad = imm[0];
            end
            32'h37, 32'h17: w = (imm & 32'hFFFFF000) | (rd << 7) | op;
            default: bad = 1;
        endcase
        return {bad, w};
    endfunction

    always @(negedge clk) begin
        bit        exp_rdy, exp_we, acc, wr;
        bit [32:0] e;
        if (!reset_n) begin
            q.delete();
            exp_addr  = 0;
            exp_count = 0;
            exp_done  = 0;
            live      = 0;
            pend_ill  = 0;
        end else begin
            exp_rdy = live && !exp_done && q.size() < DEPTH && !clear;
            exp_we  = !exp_done && q.size() > 0;
            check("in_ready", bus.in_ready, exp_rdy);
            check("mem_we", bus.mem_we, exp_we);
            check("illegal", illegal, pend_ill);
            check("count", count, exp_count);
            check("done", done, exp_done);
            if (illegal) ill_seen++;
            if (exp_we) begin
                check("mem_addr", bus.mem_addr, exp_addr);
                check("mem_wdata", bus.mem_wdata, q[0]);
            end
            wr  = exp_we && bus.mem_ready && !clear;
            acc = bus.in_valid && exp_rdy;
            e   = ref_enc(bus.in_opcode, bus.in_funct3, bus.in_funct7,
                          bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_imm);
            pend_ill = acc && e[32];
            if (clear) begin
                q.delete();
                exp_addr  = 0;
                exp_count = 0;
                exp_done  = 0;
            end else begin
                if (wr) begin
                    wlog[exp_addr] = bus.mem_wdata;
                    void'(q.pop_front());
                    exp_count++;
                    if (exp_addr == NW - 1) begin
                        exp_done = 1;
                        q.delete();
                    end else begin
                        exp_addr++;
                    end
                end
                if (acc && !e[32] && !exp_done) q.push_back(e[31:0]);
            end
            live = 1;
        end
    end

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_fields(bit [6:0] op, bit [2:0] f3, bit [6:0] f7,
                              bit [4:0] rd, bit [4:0] rs1, bit [4:0] rs2,
                              bit [31:0] imm);
        bus.in_opcode = op;
        bus.in_funct3 = f3;
        bus.in_funct7 = f7;
        bus.in_rd     = rd;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_imm    = imm;
    endtask

    task automatic send(bit [6:0] op, bit [2:0] f3, bit [6:0] f7,
                        bit [4:0] rd, bit [4:0] rs1, bit [4:0] rs2,
                        bit [31:0] imm);
        bit r;
        r = 0;
        set_fields(op, f3, f7, rd, rs1, rs2, imm);
        bus.in_valid = 1'b1;
        for (int n = 0; n < 200 && !r; n++) begin
            @(negedge clk);
            r = bus.in_ready;
            @(posedge clk);
            #2;
        end
        if (!r) check("send_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic do_clear();
        for (int i = 0; i < NW; i++) wlog[i] = 32'hDEADBEEF;
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_in_ready"}, bus.in_ready, 0);
        check({tag, "_mem_we"}, bus.mem_we, 0);
        check({tag, "_mem_addr"}, bus.mem_addr, 0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        check({tag, "_illegal"}, illegal, 0);
        check({tag, "_count"}, count, 0);
        check({tag, "_done"}, done, 0);
    endtask

    bit [6:0] ops[10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23,
                          7'h63, 7'h6F, 7'h37, 7'h17, 7'h7F};

    initial begin
        int base;
        bit [31:0] imm;
        bit [6:0] op;
        ill_seen      = 0;
        bus.in_valid  = 1'b0;
        bus.mem_ready = 1'b1;
        set_fields(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < NW; i++) wlog[i] = 32'hDEADBEEF;

        idle(2);
        check_reset_outputs("rst");
        reset_n = 1'b1;
        idle(1);

        send(7'h13, 0, 0, 1, 0, 0, 5);
        idle(3);
        check("addi_word", wlog[0], 32'h00500093);
        check("addi_count", count, 1);

        do_clear();
        send(7'h33, 0, 0, 3, 1, 2, 0);
        send(7'h23, 3'b010, 0, 0, 1, 2, 8);
        idle(4);
        check("add_word", wlog[0], 32'h002081B3);
        check("sw_word", wlog[1], 32'h0020A423);

        do_clear();
        send(7'h63, 0, 0, 0, 1, 2, -32'sd4);
        send(7'h6F, 0, 0, 1, 0, 0, 2048);
        idle(4);
        check("beq_word", wlog[0], 32'hFE208EE3);
        check("jal_word", wlog[1], 32'h001000EF);

        do_clear();
        bus.mem_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(7'h13, 0, 0, i[4:0], 0, 0, i);
        @(negedge clk);
        check("full_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #2;
        set_fields(7'h13, 0, 0, 5, 0, 0, 5);
        bus.in_valid = 1'b1;
        idle(2);
        check("full_no_write", count, 0);
        bus.mem_ready = 1'b1;
        send(7'h13, 0, 0, 5, 0, 0, 5);
        idle(6);
        for (int i = 1; i <= 5; i++)
            check("full_order", wlog[i-1], (i << 20) | (i << 7) | 32'h13);

        do_clear();
        base = ill_seen;
        send(7'h7F, 0, 0, 1, 2, 3, 0);
        send(7'h6F, 0, 0, 1, 0, 0, 3);
        idle(3);
        check("ill_pulses", ill_seen - base, 2);
        check("ill_count", count, 0);

        do_clear();
        for (int i = 0; i < NW; i++) send(7'h37, 0, 0, 1, 0, 0, i << 12);
        idle(3);
        check("done_flag", done, 1);
        check("done_in_ready", bus.in_ready, 0);
        check("done_mem_we", bus.mem_we, 0);
        check("done_count", count, NW);
        do_clear();
        check("clr_addr", bus.mem_addr, 0);
        check("clr_count", count, 0);
        check("clr_done", done, 0);

        for (int c = 0; c < 3000; c++) begin
            op  = ops[$urandom_range(0, 9)];
            imm = $urandom;
            if ($urandom_range(0, 3) != 0) imm[0] = 1'b0;
            set_fields(op, $urandom, $urandom, $urandom, $urandom,
                       $urandom, imm);
            bus.in_valid  = $urandom_range(0, 1);
            bus.mem_ready = ($urandom_range(0, 3) != 0);
            clear         = ($urandom_range(0, 39) == 0);
            idle(1);
        end
        clear        = 1'b0;
        bus.in_valid = 1'b0;

        do_clear();
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(7'h33, 0, 0, 1, 2, 3, 0);
        #1;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async");
        idle(2);
        reset_n = 1'b1;
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
